ecap5_dwbmem_arbiter: RTL and testbench
=======================================

# ecap5_dwbmem_arbiter

Two-master pipelined Wishbone arbiter that shares a single ECAP5-DWBMEM-BRAM slave port between an instruction-side master (m0) and a data-side master (m1). The arbiter grants the slave to one master for the whole of its `cyc` assertion and tracks in-flight requests so that every ack and read word is routed back to the master that issued the request. It sits between the core's bus masters and the BRAM memory block. Arbitration is round-robin by default; fixed priority is available as a compile option.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unacked requests; counter width is `$clog2(MAX_OUTSTANDING+1)`.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `m0_wb_adr_i`, `m1_wb_adr_i` in 32: master address.
- `m0_wb_dat_i`, `m1_wb_dat_i` in 32: master write data.
- `m0_wb_dat_o`, `m1_wb_dat_o` out 32: read data; 0 when the master is not the owner.
- `m0_wb_we_i`, `m1_wb_we_i` in 1: write enable.
- `m0_wb_sel_i`, `m1_wb_sel_i` in 4: byte select.
- `m0_wb_stb_i`, `m1_wb_stb_i` in 1: request strobe.
- `m0_wb_cyc_i`, `m1_wb_cyc_i` in 1: cycle; this is the bus request.
- `m0_wb_ack_o`, `m1_wb_ack_o` out 1: ack routed to the owner.
- `m0_wb_stall_o`, `m1_wb_stall_o` out 1: stall.
- `s_wb_adr_o` out 32, `s_wb_dat_o` out 32, `s_wb_we_o` out 1, `s_wb_sel_o` out 4: owner's request fields.
- `s_wb_stb_o`, `s_wb_cyc_o` out 1: owner's strobe and cycle, gated as described under Operation.
- `s_wb_dat_i` in 32, `s_wb_ack_i` in 1, `s_wb_stall_i` in 1: slave response.

## Operation
- **State machine:** IDLE, GNT0, GNT1. Internal registers are `last` (1 bit, last granted master) and `cnt` (outstanding count).
- **IDLE:**
  - Both stalls are 1 and all slave outputs are 0.
  - If only one `cyc` is high, grant that master.
  - If both `cyc` are high, grant `!last`.
  - Entering a grant state sets `last` to the granted master.
- **GNTx:**
  - Slave outputs are driven combinationally from master x.
  - `s_wb_stb_o = mx_stb & (cnt != MAX_OUTSTANDING)`.
  - `mx_stall_o = s_wb_stall_i | (cnt == MAX_OUTSTANDING)`.
  - The other master's stall is 1.
  - `mx_ack_o = s_wb_ack_i` and `mx_dat_o = s_wb_dat_i`.
- **Counter:** `cnt` increments on an accepted strobe (`s_wb_stb_o & !s_wb_stall_i`) and decrements on `s_wb_ack_i`. If both happen in the same cycle, `cnt` is unchanged.
  - `cnt` saturates at 0 and at `MAX_OUTSTANDING`.
  - An ack received while `cnt == 0` is dropped and not forwarded.
- **Release condition:** `mx_cyc` is low and the next value of `cnt` is 0. Any acks arriving after `mx_cyc` drops are still routed to master x until `cnt` reaches 0.
- **On release:**
  - If the other master's `cyc` is high, hand over directly to GNT(other) with no IDLE cycle.
  - Otherwise go to IDLE.
- **`s_wb_cyc_o`:** equals `mx_cyc | (cnt != 0)` while in GNTx, so the slave cycle stays open until every in-flight ack has returned.

## Timing
- **Reset values** (`rst_i` low, asynchronous):
  - State is IDLE, `cnt = 0`, `last = 1`, so m0 wins the first tie.
  - Every master stall output is 1.
  - Every ack, data, `stb` and `cyc` output is 0.
- **Reset asserted mid-transaction:** all in-flight requests are abandoned and there is no ack replay.
- **Grant latency:** from IDLE, the grant takes effect 1 cycle after `cyc` rises. The master sees `stall = 1` in the cycle `cyc` rises and can issue its first accepted strobe the next cycle.
- **Handover latency:** the new owner's strobe can be accepted in the cycle after the release condition is met.
- **Response path:** ack and read data pass combinationally slave to master with zero added latency. With the BRAM's 1-cycle response, back-to-back reads sustain 1 word per cycle at `MAX_OUTSTANDING >= 2`.
- **Request path:** the request path is combinational from the owning master to the slave. The grant state is registered, so there is no combinational path from one master to the other master's outputs.

## Configuration
- **`ECAP5_DWBMEM_ARB_FIXED_PRIO_EN` defined:**
  - m0 always wins when both masters request, both from IDLE and at handover; `last` is ignored.
  - m1 can starve while m0 keeps `cyc` asserted. This is accepted behaviour.
- **Not defined:** round-robin arbitration as described under Operation.

## Test plan
- **Single read:** m0 read at `0x10`, with the slave returning `0xDEADBEEF` one cycle later -> `m0_wb_ack_o` pulses once with `m0_wb_dat_o = 0xDEADBEEF`; `m1_wb_dat_o` stays 0.
- **Simultaneous requests from reset:** both `cyc` rise together -> m0 is granted first; on m0 release, direct handover to m1 with no IDLE cycle; a following tie goes to m0 again. With the macro defined, m0 wins every tie.
- **Outstanding limit:** 4 back-to-back strobes from m1 with the slave ack delayed 3 cycles and `MAX_OUTSTANDING = 2` -> `m1_wb_stall_o` is high while `cnt = 2`; exactly 4 acks reach m1 and none reach m0.
- **Early `cyc` drop:** m0 drops `cyc` with `cnt = 1` -> the grant holds, the pending ack reaches m0, and m1 is granted the cycle after `cnt` reaches 0.
- **Spurious ack and reset:** a slave ack in IDLE is not forwarded to either master; `rst_i` pulsed low in GNT1 with `cnt = 1` -> outputs return to reset values immediately and state is IDLE.

Source files
------------

// File: rtl/ecap5_dwbmem_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the DWBMEM BRAM slave port.
// Round-robin by default; define ECAP5_DWBMEM_ARB_FIXED_PRIO_EN for fixed m0 priority.
module ecap5_dwbmem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,

  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cnt_full;
  logic               cnt_zero;
  logic               accept;

  assign cnt_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign cnt_zero = (cnt_q == '0);

  // State, last-grant and outstanding-count registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus muxing, outstanding counter and grant/release decisions
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = '0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    m0_wb_dat_o   = '0;
    m1_wb_dat_o   = '0;

    case (state_q)
      GNT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_stb_o    = m0_wb_stb_i & ~cnt_full;
        s_wb_cyc_o    = m0_wb_cyc_i | ~cnt_zero;
        m0_wb_stall_o = s_wb_stall_i | cnt_full;
        m0_wb_ack_o   = s_wb_ack_i & ~cnt_zero;
        m0_wb_dat_o   = s_wb_dat_i;
      end
      GNT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_stb_o    = m1_wb_stb_i & ~cnt_full;
        s_wb_cyc_o    = m1_wb_cyc_i | ~cnt_zero;
        m1_wb_stall_o = s_wb_stall_i | cnt_full;
        m1_wb_ack_o   = s_wb_ack_i & ~cnt_zero;
        m1_wb_dat_o   = s_wb_dat_i;
      end
      default: ;
    endcase

    // Simultaneous accept and ack cancel; acks with nothing in flight are dropped
    accept = s_wb_stb_o & ~s_wb_stall_i;
    if (accept && !s_wb_ack_i && !cnt_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && s_wb_ack_i && !cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // At handover the releasing master has dropped cyc, so priority mode only matters from IDLE
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
`ifdef ECAP5_DWBMEM_ARB_FIXED_PRIO_EN
          state_d = GNT0;
          last_d  = 1'b0;
`else
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
`endif
        end else if (m0_wb_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_wb_cyc_i && (cnt_d == '0)) begin
          if (m1_wb_cyc_i) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_i && (cnt_d == '0)) begin
          if (m0_wb_cyc_i) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ecap5_dwbmem_arbiter.sv
// Self-checking bench for ecap5_dwbmem_arbiter: directed scenarios plus random traffic
// against an owner/in-flight-count reference model and a FIFO slave with random latency.
module tb_ecap5_dwbmem_arbiter;

  localparam int MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic        m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i, m0_wb_ack_o, m0_wb_stall_o;
  logic [3:0]  m0_wb_sel_i;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic        m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i, m1_wb_ack_o, m1_wb_stall_o;
  logic [3:0]  m1_wb_sel_i;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic        s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_stall_i;
  logic [3:0]  s_wb_sel_o;

  always #5 clk_i = ~clk_i;

  ecap5_dwbmem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_dat_o(m0_wb_dat_o),
    .m0_wb_we_i(m0_wb_we_i), .m0_wb_sel_i(m0_wb_sel_i), .m0_wb_stb_i(m0_wb_stb_i),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_stall_o(m0_wb_stall_o),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_dat_o(m1_wb_dat_o),
    .m1_wb_we_i(m1_wb_we_i), .m1_wb_sel_i(m1_wb_sel_i), .m1_wb_stb_i(m1_wb_stb_i),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_stall_o(m1_wb_stall_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_sel_o(s_wb_sel_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_cyc_o(s_wb_cyc_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_stall_i(s_wb_stall_i)
  );

  // Reference model: who owns the slave (-1 = nobody), how many requests are in flight
  int          own, mcnt, mlast;
  int          cyc_no;
  int          due_q[$];
  logic [31:0] rdat_q[$];
  int          fix_delay;
  logic        spur;
  logic        last_acc;
  int          ack0_seen, ack1_seen;
  logic [31:0] last_dat0;
  int          total, bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_ctl();
    return 32'({s_wb_stb_o, s_wb_cyc_o, s_wb_we_o, s_wb_sel_o,
                m0_wb_stall_o, m1_wb_stall_o, m0_wb_ack_o, m1_wb_ack_o});
  endfunction

  task automatic model_reset();
    own = -1; mcnt = 0; mlast = 1;
    due_q.delete(); rdat_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, dut_ctl(), 32'h0000_000C);
    check({tag, "_sadr"}, s_wb_adr_o, 32'h0);
    check({tag, "_sdat"}, s_wb_dat_o, 32'h0);
    check({tag, "_d0"}, m0_wb_dat_o, 32'h0);
    check({tag, "_d1"}, m1_wb_dat_o, 32'h0);
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr);
    if (m == 0) begin
      m0_wb_cyc_i = cyc; m0_wb_stb_i = stb; m0_wb_we_i = we; m0_wb_adr_i = adr;
      m0_wb_dat_i = $urandom(); m0_wb_sel_i = 4'hF;
    end else begin
      m1_wb_cyc_i = cyc; m1_wb_stb_i = stb; m1_wb_we_i = we; m1_wb_adr_i = adr;
      m1_wb_dat_i = $urandom(); m1_wb_sel_i = 4'hF;
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    s_wb_ack_i = 1'b0; s_wb_dat_i = 32'h0; s_wb_stall_i = 1'b0; spur = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("por");
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc_no++;
  endtask

  // One bus cycle: slave drives its response, outputs are compared, then the model advances
  task automatic step();
    logic real_ack, xc, xs, xwe, oc, xstall, xack, acc;
    logic [31:0] xadr, xdat;
    logic [3:0] xsel;
    logic e_stb, e_cyc, e_we, e_st0, e_st1, e_ack0, e_ack1;
    logic [3:0] e_sel;
    logic [31:0] e_sadr, e_sdat, e_d0, e_d1;
    int d, due;

    real_ack = (due_q.size() > 0) && (due_q[0] <= cyc_no);
    if (real_ack) begin
      s_wb_ack_i = 1'b1;
      s_wb_dat_i = rdat_q[0];
    end else begin
      s_wb_ack_i = spur && (own < 0);
      s_wb_dat_i = s_wb_ack_i ? $urandom() : 32'h0;
    end
    #2;

    e_stb = 1'b0; e_cyc = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_st0 = 1'b1; e_st1 = 1'b1;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_sadr = 32'h0; e_sdat = 32'h0; e_d0 = 32'h0; e_d1 = 32'h0;
    xc = 1'b0;
    if (own >= 0) begin
      xc   = (own == 0) ? m0_wb_cyc_i : m1_wb_cyc_i;
      xs   = (own == 0) ? m0_wb_stb_i : m1_wb_stb_i;
      xwe  = (own == 0) ? m0_wb_we_i  : m1_wb_we_i;
      xadr = (own == 0) ? m0_wb_adr_i : m1_wb_adr_i;
      xdat = (own == 0) ? m0_wb_dat_i : m1_wb_dat_i;
      xsel = (own == 0) ? m0_wb_sel_i : m1_wb_sel_i;
      e_sadr = xadr; e_sdat = xdat; e_we = xwe; e_sel = xsel;
      e_stb  = xs && (mcnt < MAXO);
      e_cyc  = xc || (mcnt != 0);
      xstall = s_wb_stall_i || (mcnt == MAXO);
      xack   = s_wb_ack_i && (mcnt != 0);
      if (own == 0) begin
        e_st0 = xstall; e_ack0 = xack; e_d0 = s_wb_dat_i;
      end else begin
        e_st1 = xstall; e_ack1 = xack; e_d1 = s_wb_dat_i;
      end
    end

    check($sformatf("ctl c%0d", cyc_no), dut_ctl(),
          32'({e_stb, e_cyc, e_we, e_sel, e_st0, e_st1, e_ack0, e_ack1}));
    check($sformatf("sadr c%0d", cyc_no), s_wb_adr_o, e_sadr);
    check($sformatf("sdat c%0d", cyc_no), s_wb_dat_o, e_sdat);
    check($sformatf("d0 c%0d", cyc_no), m0_wb_dat_o, e_d0);
    check($sformatf("d1 c%0d", cyc_no), m1_wb_dat_o, e_d1);

    if (m0_wb_ack_o) begin
      ack0_seen++;
      last_dat0 = m0_wb_dat_o;
    end
    if (m1_wb_ack_o) ack1_seen++;

    acc = e_stb && !s_wb_stall_i;
    last_acc = acc;
    if (acc) begin
      d = (fix_delay > 0) ? fix_delay : int'($urandom_range(3, 1));
      due = cyc_no + d;
      if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
      due_q.push_back(due);
      rdat_q.push_back(e_sadr ^ 32'hDEAD_BEFF);
    end
    if (real_ack) begin
      void'(due_q.pop_front());
      void'(rdat_q.pop_front());
    end
    if (acc && !s_wb_ack_i) mcnt++;
    else if (!acc && s_wb_ack_i && mcnt > 0) mcnt--;

    if (own < 0) begin
      if (m0_wb_cyc_i && m1_wb_cyc_i) begin
`ifdef ECAP5_DWBMEM_ARB_FIXED_PRIO_EN
        own = 0;
`else
        own = (mlast == 1) ? 0 : 1;
`endif
      end else if (m0_wb_cyc_i) own = 0;
      else if (m1_wb_cyc_i) own = 1;
      if (own >= 0) mlast = own;
    end else if (!xc && mcnt == 0) begin
      oc  = (own == 0) ? m1_wb_cyc_i : m0_wb_cyc_i;
      own = oc ? 1 - own : -1;
      if (own >= 0) mlast = own;
    end

    @(posedge clk_i);
    #1;
    cyc_no++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    total = 0; bad = 0; cyc_no = 0; fix_delay = 1; spur = 1'b0;
    ack0_seen = 0; ack1_seen = 0; last_dat0 = 32'h0; last_acc = 1'b0;
    model_reset();
    apply_reset();

    // Single read from m0
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10);
    step();
    step();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h10);
    step();
    check("t1_ack0", 32'(ack0_seen), 32'd1);
    check("t1_rdat", last_dat0, 32'hDEAD_BEEF);
    check("t1_ack1", 32'(ack1_seen), 32'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Simultaneous requests from reset, handover, second tie
    apply_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 32'h100);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h200);
    step();
    check("t2_first", s_wb_adr_o, 32'h100);
    step();
    m0_wb_cyc_i = 1'b0;
    step();
    check("t2_hand", s_wb_adr_o, 32'h200);
    check("t2_hcyc", 32'(s_wb_cyc_o), 32'd1);
    m1_wb_cyc_i = 1'b0;
    step();
    m0_wb_cyc_i = 1'b1;
    m1_wb_cyc_i = 1'b1;
    step();
    check("t2_tie2", s_wb_adr_o, 32'h100);
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Outstanding limit: four strobes from m1, slave ack 3 cycles late
    fix_delay = 3; ack0_seen = 0; ack1_seen = 0; issued = 0;
    for (int i = 0; i < 40 && !(issued == 4 && mcnt == 0 && i > 0); i++) begin
      set_m(1, 1'b1, issued < 4, 1'b0, 32'h40 + 32'(issued * 4));
      step();
      if (last_acc) issued++;
    end
    check("t3_issued", 32'(issued), 32'd4);
    check("t3_ack1", 32'(ack1_seen), 32'd4);
    check("t3_ack0", 32'(ack0_seen), 32'd0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Early cyc drop by m0 with one request in flight, m1 waiting
    fix_delay = 2; ack0_seen = 0; ack1_seen = 0;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h80);
    set_m(1, 1'b1, 1'b0, 1'b0, 32'h300);
    step();
    step();
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h80);
    step();
    check("t4_hold", s_wb_adr_o, 32'h80);
    step();
    check("t4_ack0", 32'(ack0_seen), 32'd1);
    check("t4_gnt1", s_wb_adr_o, 32'h300);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Spurious ack in IDLE, then reset while m1 has one request in flight
    ack0_seen = 0; ack1_seen = 0; spur = 1'b1;
    step();
    spur = 1'b0;
    check("t5_spur0", 32'(ack0_seen), 32'd0);
    check("t5_spur1", 32'(ack1_seen), 32'd0);
    fix_delay = 3;
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h500);
    step();
    step();
    set_m(1, 1'b1, 1'b0, 1'b1, 32'h500);
    step();
    check("t5_pre", s_wb_adr_o, 32'h500);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset("rst_mid");
    model_reset();
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
    s_wb_ack_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cyc_no++;
    ack1_seen = 0;
    repeat (4) step();
    check("t5_noreplay", 32'(ack1_seen), 32'd0);

    // Random traffic from both masters against a random-latency, randomly stalling slave
    fix_delay = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7, 0) == 0) m0_wb_cyc_i = ~m0_wb_cyc_i;
      if ($urandom_range(7, 0) == 0) m1_wb_cyc_i = ~m1_wb_cyc_i;
      m0_wb_stb_i = m0_wb_cyc_i & 1'($urandom_range(1, 0));
      m1_wb_stb_i = m1_wb_cyc_i & 1'($urandom_range(1, 0));
      m0_wb_we_i  = 1'($urandom_range(1, 0));
      m1_wb_we_i  = 1'($urandom_range(1, 0));
      m0_wb_adr_i = $urandom() & 32'hFFFF_FFFC;
      m1_wb_adr_i = $urandom() & 32'hFFFF_FFFC;
      m0_wb_dat_i = $urandom();
      m1_wb_dat_i = $urandom();
      m0_wb_sel_i = 4'($urandom_range(15, 0));
      m1_wb_sel_i = 4'($urandom_range(15, 0));
      s_wb_stall_i = ($urandom_range(3, 0) == 0);
      spur = (own < 0) && ($urandom_range(3, 0) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
